// File: rtl/piano_pkg.sv
// Shared piano definitions: key indices, half-period table and note FSM states.
package piano_pkg;

   localparam int unsigned NUM_KEYS = 8;
   localparam int unsigned IDX_W    = 3;
   localparam int unsigned HP_W     = 19;

   // Key index constants, bit position in the keys bus
   localparam logic [IDX_W-1:0] KEY_C4  = 3'd0;
   localparam logic [IDX_W-1:0] KEY_D4  = 3'd1;
   localparam logic [IDX_W-1:0] KEY_E4  = 3'd2;
   localparam logic [IDX_W-1:0] KEY_F4  = 3'd3;
   localparam logic [IDX_W-1:0] KEY_FS4 = 3'd4;
   localparam logic [IDX_W-1:0] KEY_G4  = 3'd5;
   localparam logic [IDX_W-1:0] KEY_A4  = 3'd6;
   localparam logic [IDX_W-1:0] KEY_B4  = 3'd7;

   // Half-period terminal counts at 50 MHz
   localparam logic [HP_W-1:0] HP_C4  = 19'd95554;
   localparam logic [HP_W-1:0] HP_D4  = 19'd85130;
   localparam logic [HP_W-1:0] HP_E4  = 19'd75841;
   localparam logic [HP_W-1:0] HP_F4  = 19'd71585;
   localparam logic [HP_W-1:0] HP_FS4 = 19'd67569;
   localparam logic [HP_W-1:0] HP_G4  = 19'd63774;
   localparam logic [HP_W-1:0] HP_A4  = 19'd56817;
   localparam logic [HP_W-1:0] HP_B4  = 19'd50618;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } note_state_t;

   // Table lookup: key index to half-period terminal count
   function automatic logic [HP_W-1:0] half_period_of(input logic [IDX_W-1:0] idx);
      logic [HP_W-1:0] hp;
      case (idx)
         KEY_C4:  hp = HP_C4;
         KEY_D4:  hp = HP_D4;
         KEY_E4:  hp = HP_E4;
         KEY_F4:  hp = HP_F4;
         KEY_FS4: hp = HP_FS4;
         KEY_G4:  hp = HP_G4;
         KEY_A4:  hp = HP_A4;
         default: hp = HP_B4;
      endcase
      return hp;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer followed by a saturating stability counter.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic stable
);

   localparam int unsigned    CW      = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Synchronize, then accept a change only after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt >= CNT_MAX - CW'(1)) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/key_note_sel.sv
// Debounced 8-key piano front end: priority note select, note FSM and half-period lookup.
module key_note_sel
   import piano_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] keys,
   output logic                note_on,
   output logic [IDX_W-1:0]    note_idx,
   output logic [HP_W-1:0]     half_period,
   output logic                note_change
);

   logic [NUM_KEYS-1:0] db;
   logic [IDX_W-1:0]    sel;
   note_state_t         state;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .rst    (rst),
         .key    (keys[i]),
         .stable (db[i])
      );
   end

   // Fixed priority: lowest-index debounced key wins
   always_comb begin
      sel = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (db[i]) sel = IDX_W'(i);
      end
   end

   // Note FSM; idx/half_period hold in IDLE so the tone finishes its half-cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         note_on     <= 1'b0;
         note_idx    <= KEY_C4;
         half_period <= HP_C4;
         note_change <= 1'b0;
      end else begin
         note_change <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|db) begin
                  state       <= ST_ACTIVE;
                  note_on     <= 1'b1;
                  note_idx    <= sel;
                  half_period <= half_period_of(sel);
                  note_change <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (db == '0) begin
                  state       <= ST_IDLE;
                  note_on     <= 1'b0;
                  note_change <= 1'b1;
               end else if (sel != note_idx) begin
                  note_idx    <= sel;
                  half_period <= half_period_of(sel);
                  note_change <= 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               note_on <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_note_sel.sv
// Bench for key_note_sel with DEBOUNCE_CYCLES=4: per-cycle reference model plus directed cases.
module tb_key_note_sel;

   localparam int unsigned DC = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  keys = 8'h00;
   logic        note_on;
   logic [2:0]  note_idx;
   logic [18:0] half_period;
   logic        note_change;

   int total = 0;
   int bad   = 0;

   key_note_sel #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk         (clk),
      .rst         (rst),
      .keys        (keys),
      .note_on     (note_on),
      .note_idx    (note_idx),
      .half_period (half_period),
      .note_change (note_change)
   );

   always #5 clk = ~clk;

   // Reference model state
   int          hp_tbl [8] = '{95554, 85130, 75841, 71585, 67569, 63774, 56817, 50618};
   logic [7:0]  hist [0:DC];   // hist[j] = raw keys sampled j+1 edges ago
   logic [7:0]  m_db;
   int          m_on, m_idx, m_hp, m_chg;

   typedef struct {
      logic [7:0] k;
      int         idx;
      int         hp;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // One clock edge of the reference: a key's stable state flips once its
   // synchronized value (raw delayed two edges) has differed for DC samples.
   task automatic model_edge(input logic [7:0] k, input logic r);
      int  new_on, new_idx;
      logic all_diff;
      if (r) begin
         m_db = 8'h00;
         for (int j = 0; j <= DC; j++) hist[j] = 8'h00;
         m_on = 0; m_idx = 0; m_hp = 95554; m_chg = 0;
      end else begin
         new_on  = (m_db != 8'h00) ? 1 : 0;
         new_idx = m_idx;
         if (new_on == 1) begin
            for (int b = 7; b >= 0; b--) if (m_db[b]) new_idx = b;
         end
         m_chg = ((new_on != m_on) || (new_idx != m_idx)) ? 1 : 0;
         m_on  = new_on;
         m_idx = new_idx;
         m_hp  = hp_tbl[m_idx];
         for (int b = 0; b < 8; b++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= DC; j++) if (hist[j][b] == m_db[b]) all_diff = 1'b0;
            if (all_diff) m_db[b] = ~m_db[b];
         end
         for (int j = DC; j >= 1; j--) hist[j] = hist[j-1];
         hist[0] = k;
      end
   endtask

   task automatic step(input logic [7:0] k, input logic r);
      keys = k;
      rst  = r;
      @(posedge clk);
      model_edge(k, r);
      #1;
      chk("model_note_on",     int'(note_on),     m_on);
      chk("model_note_idx",    int'(note_idx),    m_idx);
      chk("model_half_period", int'(half_period), m_hp);
      chk("model_note_change", int'(note_change), m_chg);
   endtask

   initial begin
      vec_t vecs [11];
      int   rise, pulses, lows, hold, cyc;
      logic [7:0] rk;

      vecs[0]  = '{8'h01, 0, 95554};
      vecs[1]  = '{8'h02, 1, 85130};
      vecs[2]  = '{8'h04, 2, 75841};
      vecs[3]  = '{8'h08, 3, 71585};
      vecs[4]  = '{8'h10, 4, 67569};
      vecs[5]  = '{8'h20, 5, 63774};
      vecs[6]  = '{8'h40, 6, 56817};
      vecs[7]  = '{8'h80, 7, 50618};
      vecs[8]  = '{8'hC0, 6, 56817};
      vecs[9]  = '{8'hFF, 0, 95554};
      vecs[10] = '{8'h28, 3, 71585};

      // Reset values
      step(8'h00, 1'b1);
      step(8'h00, 1'b1);
      chk("reset_note_on",     int'(note_on),     0);
      chk("reset_note_idx",    int'(note_idx),    0);
      chk("reset_half_period", int'(half_period), 95554);
      chk("reset_note_change", int'(note_change), 0);

      // Single F#4 press
      rise = 0; pulses = 0;
      for (int c = 1; c <= 15; c++) begin
         step(8'h10, 1'b0);
         pulses += int'(note_change);
         if (note_on && rise == 0) rise = c;
      end
      chk("fs4_rise_window", (rise >= 6 && rise <= 7) ? 1 : 0, 1);
      chk("fs4_pulses", pulses, 1);
      chk("fs4_idx", int'(note_idx), 4);
      chk("fs4_hp", int'(half_period), 67569);

      // Bouncing E4 then held
      step(8'h00, 1'b1);
      lows = 0;
      for (int c = 0; c < 20; c++) begin
         step(((c / 2) % 2 == 0) ? 8'h04 : 8'h00, 1'b0);
         if (note_on) lows++;
      end
      chk("bounce_no_note", lows, 0);
      rise = 0;
      for (int c = 1; c <= 20; c++) begin
         step(8'h04, 1'b0);
         if (note_on && rise == 0) rise = c;
      end
      chk("bounce_rise_window", (rise >= 6 && rise <= 7) ? 1 : 0, 1);
      chk("bounce_idx", int'(note_idx), 2);
      chk("bounce_hp", int'(half_period), 75841);

      // C4+B4 together, then C4 released
      step(8'h00, 1'b1);
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         step(8'h81, 1'b0);
         pulses += int'(note_change);
      end
      chk("dual_pulses", pulses, 1);
      chk("dual_idx", int'(note_idx), 0);
      chk("dual_hp", int'(half_period), 95554);
      lows = 0; pulses = 0;
      for (int c = 0; c < 12; c++) begin
         step(8'h80, 1'b0);
         pulses += int'(note_change);
         if (!note_on) lows++;
      end
      chk("handover_no_gap", lows, 0);
      chk("handover_pulses", pulses, 1);
      chk("handover_idx", int'(note_idx), 7);
      chk("handover_hp", int'(half_period), 50618);

      // Release all keys
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         step(8'h00, 1'b0);
         pulses += int'(note_change);
      end
      chk("release_note_on", int'(note_on), 0);
      chk("release_pulses", pulses, 1);
      chk("release_hp_hold", int'(half_period), 50618);

      // Reset while F4 note is sounding
      for (int c = 0; c < 10; c++) step(8'h08, 1'b0);
      chk("pre_rst_note_on", int'(note_on), 1);
      step(8'h08, 1'b1);
      chk("mid_rst_note_on", int'(note_on), 0);
      chk("mid_rst_hp", int'(half_period), 95554);
      rise = 0;
      for (int c = 1; c <= 15; c++) begin
         step(8'h08, 1'b0);
         if (note_on && rise == 0) rise = c;
      end
      chk("redebounce_rise_window", (rise >= 6 && rise <= 7) ? 1 : 0, 1);
      chk("redebounce_idx", int'(note_idx), 3);
      chk("redebounce_hp", int'(half_period), 71585);

      // Table of held key patterns from reset
      foreach (vecs[v]) begin
         step(8'h00, 1'b1);
         for (int c = 0; c < 10; c++) step(vecs[v].k, 1'b0);
         chk("vec_note_on", int'(note_on), 1);
         chk("vec_idx", int'(note_idx), vecs[v].idx);
         chk("vec_hp", int'(half_period), vecs[v].hp);
      end

      // Random key activity with occasional reset, checked every cycle by the model
      cyc = 0;
      while (cyc < 3000) begin
         hold = int'($urandom_range(1, 10));
         case ($urandom_range(0, 3))
            0:       rk = 8'h00;
            1:       rk = 8'h01 << $urandom_range(0, 7);
            default: rk = 8'($urandom);
         endcase
         if ($urandom_range(0, 49) == 0) begin
            step(rk, 1'b1);
            cyc++;
         end
         for (int c = 0; c < hold; c++) begin
            step(rk, 1'b0);
            cyc++;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_note_sel.md
KEY_NOTE_SEL -- requirements
Module: key_note_sel

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable clk cycles (20 ms at 50 MHz) before a key change is accepted.
REQ-002 SHALL have port clk, input, 1, the single 50 MHz system clock; all logic on posedge clk.
REQ-003 SHALL have port rst, input, 1, the reset, synchronous and active-high.
REQ-004 SHALL have port keys, input, 8, raw asynchronous active-high piano keys; bit 0..7 = C4, D4, E4, F4, F#4, G4, A4, B4.
REQ-005 SHALL have port note_on, output, 1, high while at least one debounced key is held.
REQ-006 SHALL have port note_idx, output, 3, the index of the selected key.
REQ-007 SHALL have port half_period, output, 19, the terminal count for the downstream square-wave counter; the speaker toggles when the counter equals this value.
REQ-008 SHALL have port note_change, output, 1, a one-cycle pulse whenever note_on or note_idx changes.

Function
REQ-009 SHALL pass each keys bit through a 2-flop synchronizer before any other use.
REQ-010 SHALL debounce each key independently: its stable state updates only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any return to the stable value clears that key's counter.
REQ-011 SHALL make the debounced state visible no earlier than 2 + DEBOUNCE_CYCLES cycles after a clean raw edge, and no later than 3 + DEBOUNCE_CYCLES cycles.
REQ-012 SHALL select the lowest-index key among the debounced pressed keys (fixed priority).
REQ-013 SHALL implement a 2-state FSM. IDLE: on any debounced key, go to ACTIVE. ACTIVE: when no debounced key remains, go to IDLE. note_on = (state == ACTIVE).
REQ-014 SHALL, in ACTIVE, register note_idx and half_period from the selection one cycle after the debounced state changes.
REQ-015 SHALL map half_period by index: 0->95554, 1->85130, 2->75841, 3->71585, 4->67569, 5->63774, 6->56817, 7->50618.
REQ-016 SHALL, in IDLE, hold note_idx and half_period at their last values, so the downstream tone completes its half-cycle cleanly.
REQ-017 SHALL pulse note_change in the same cycle that note_on or note_idx takes its new registered value, and never on two consecutive cycles for one event.
REQ-018 SHALL, when the selected key and a higher-index key are pressed and the selected key is then released, move to the higher-index key with a note_change pulse and no intervening note_on low.
REQ-019 SHALL, when two keys debounce in the same cycle, select only the lower index and generate one note_change.
REQ-020 SHALL never let a debounce counter wrap; it saturates at DEBOUNCE_CYCLES.

Reset
REQ-021 SHALL, while rst is high at a clk edge, clear the synchronizers, debounce counters and debounced states to 0, set the FSM to IDLE, note_on 0, note_idx 0, half_period 95554, and note_change 0.
REQ-022 SHALL, on rst asserted mid-debounce or mid-note, abandon the operation; a key still held after reset is re-debounced from zero.

Structure
REQ-023 SHALL place the 8-entry half-period table, the key index constants and the FSM state encoding in a shared package piano_pkg, for reuse by the tone generators.
REQ-024 SHALL instantiate a per-key sub-module key_debounce (synchronizer plus counter) eight times; the selection, FSM and table logic SHALL stay at top level.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 SHALL cover: reset, then keys=8'h10 held -> note_on rises within 6-7 cycles, note_idx=4, half_period=67569, one note_change pulse.
REQ-026 SHALL cover: keys bit 2 bouncing 1/0 every 2 cycles for 20 cycles, then held -> no note_on until 4 stable cycles have passed, then note_idx=2, half_period=75841.
REQ-027 SHALL cover: keys=8'h81 applied together -> note_idx=0, half_period=95554; bit 0 then released -> note_idx=7, half_period=50618, note_on stays high, one note_change pulse.
REQ-028 SHALL cover: all keys released -> note_on falls after debounce with one note_change pulse, while half_period holds its last value.
REQ-029 SHALL cover: rst pulsed for 1 cycle while keys=8'h08 is held and note_on=1 -> note_on=0 and half_period=95554 the next cycle, then note_on returns with note_idx=3, half_period=71585 after a full re-debounce.
